// File: rtl/event_mon_pkg.sv
// Shared types and helpers for the event monitor export path.
// CRC-8 helper (poly 0x07, MSB first) used by the serializer when EVT_SER_CRC_EN is set.
package event_mon_pkg;

  localparam int EVT_W = 72;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_CRC
  } ser_state_t;

  function automatic logic [7:0] crc8_update(
    input logic [7:0] crc,
    input logic [7:0] data
  );
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/event_fifo_serializer.sv
// Drains event records from the FIFO head and streams them MSB byte first.
// Define EVT_SER_CRC_EN to append a per-record CRC-8 byte to every frame.
module event_fifo_serializer
  import event_mon_pkg::*;
#(
  parameter int W     = EVT_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [W-1:0]     fifo_peek,
  output logic             fifo_pop,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rec_count
);

  localparam int NB = W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB + 1) : 1;

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [W-1:0]     r_shreg;
  logic [IW-1:0]    r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic w_hs;
  logic w_last_data;
  logic w_final;
  logic w_load;
  logic w_send_hs;

  assign w_hs        = out_valid && out_ready;
  assign w_last_data = (r_idx == IW'(NB - 1));
  assign w_send_hs   = (r_state == S_SEND) && w_hs;

`ifdef EVT_SER_CRC_EN
  logic [7:0] r_crc;
  assign w_final = (r_state == S_CRC) && w_hs;
`else
  assign w_final = w_send_hs && w_last_data;
`endif

  // Next record loads from idle or on the closing handshake: no bubble.
  assign w_load   = !fifo_empty &&
                    ((r_state == S_IDLE) || w_final);
  assign fifo_pop = w_load;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_load) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_hs && w_last_data) begin
`ifdef EVT_SER_CRC_EN
          w_state_nxt = S_CRC;
`else
          w_state_nxt = w_load ? S_SEND : S_IDLE;
`endif
        end
      end
      S_CRC: begin
        if (w_hs) w_state_nxt = w_load ? S_SEND : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    unique case (r_state)
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = r_shreg[W-1 -: 8];
        out_sop   = (r_idx == '0);
`ifdef EVT_SER_CRC_EN
        out_eop   = 1'b0;
`else
        out_eop   = w_last_data;
`endif
      end
      S_CRC: begin
`ifdef EVT_SER_CRC_EN
        out_valid = 1'b1;
        out_data  = r_crc;
        out_eop   = 1'b1;
`else
        out_valid = 1'b0;
`endif
      end
      default: out_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_shreg <= fifo_peek;
        r_idx   <= '0;
      end else if (w_send_hs) begin
        r_shreg <= r_shreg << 8;
        r_idx   <= r_idx + 1'b1;
      end
      if (w_final) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef EVT_SER_CRC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= 8'h00;
    end else if (w_load) begin
      r_crc <= 8'h00;
    end else if (w_send_hs) begin
      r_crc <= crc8_update(r_crc, r_shreg[W-1 -: 8]);
    end
  end
`endif

  assign busy      = (r_state != S_IDLE);
  assign rec_count = r_cnt;

endmodule

// File: tb/tb_event_fifo_serializer.sv
// Directed bench for event_fifo_serializer: vector table plus reset,
// back-to-back and idle sequences; CRC frame test when EVT_SER_CRC_EN is set.
module tb_event_fifo_serializer;
  import event_mon_pkg::*;

  localparam int W  = EVT_W;
  localparam int NB = W / 8;
`ifdef EVT_SER_CRC_EN
  localparam int FL = NB + 1;
`else
  localparam int FL = NB;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_peek;
  logic          fifo_pop;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_ready;
  logic          busy;
  logic [15:0]   rec_count;

  event_fifo_serializer #(.W(W), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_peek  (fifo_peek),
    .fifo_pop   (fifo_pop),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_ready  (out_ready),
    .busy       (busy),
    .rec_count  (rec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } ob_t;

  typedef struct {
    logic [W-1:0] rec;
    logic [31:0]  rmask;
    logic [7:0]   b_first;
    logic [7:0]   b_last;
    int           ticks;
    int           ticks_crc;
  } vec_t;

  logic [W-1:0] fq[$];
  ob_t          obq[$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int vcyc     = 0;
  bit last_eop = 0;
  bit ps_stall = 0;
  logic [9:0] ps_out;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(logic [7:0] c, logic [7:0] d);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = c[7] ^ d[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_peek  = fifo_empty ? '0 : fq[0];
  endtask

  task automatic tick();
    logic p;
    logic hs;
    #1;
    p  = fifo_pop;
    hs = out_valid && out_ready;
    if (ps_stall && !rst) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({out_data, out_sop, out_eop}), 64'(ps_out));
    end
    ps_stall = out_valid && !out_ready && !rst;
    ps_out   = {out_data, out_sop, out_eop};
    if (p) begin
      pops++;
      chk("pop_nonempty", 64'(fifo_empty), 64'd0);
    end
    if (out_valid) vcyc++;
    last_eop = hs && out_eop && !rst;
    if (hs && !rst) obq.push_back('{out_data, out_sop, out_eop});
    @(posedge clk);
    #1;
    if (p && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic check_frame(logic [W-1:0] rec);
    logic [7:0] c;
    c = 8'h00;
    chk("frame_len", 64'(obq.size()), 64'(FL));
    if (obq.size() == FL) begin
      for (int i = 0; i < NB; i++) begin
        chk("byte", 64'(obq[i].d), 64'(rec[W-1-8*i -: 8]));
        c = ref_crc(c, rec[W-1-8*i -: 8]);
      end
      for (int i = 0; i < FL; i++) begin
        chk("sop_flag", 64'(obq[i].s), 64'(i == 0));
        chk("eop_flag", 64'(obq[i].e), 64'(i == FL - 1));
      end
`ifdef EVT_SER_CRC_EN
      chk("crc_byte", 64'(obq[NB].d), 64'(c));
`endif
    end
  endtask

  task automatic run_vec(vec_t v);
    int t;
    int base;
    obq.delete();
    base = int'(rec_count);
    fq.push_back(v.rec);
    drive_fifo();
    out_ready = 1'b0;
    t = 0;
    last_eop = 0;
    while (!last_eop && t < 64) begin
      tick();
      t++;
      out_ready = v.rmask[(t - 1) % 32];
    end
    out_ready = 1'b0;
`ifdef EVT_SER_CRC_EN
    chk("vec_ticks", 64'(t), 64'(v.ticks_crc));
`else
    chk("vec_ticks", 64'(t), 64'(v.ticks));
`endif
    check_frame(v.rec);
    if (obq.size() >= NB) begin
      chk("vec_first", 64'(obq[0].d), 64'(v.b_first));
      chk("vec_last", 64'(obq[NB-1].d), 64'(v.b_last));
    end
    chk("vec_count", 64'(rec_count), 64'(base + 1));
  endtask

  vec_t tv[4];

  initial begin
    int t;
    bit bad;

    tv[0] = '{72'h010203040506070809, 32'hFFFF_FFFF,
              8'h01, 8'h09, 10, 11};
    tv[1] = '{72'hA1B2C3D4E5F6071829, 32'h9999_9999,
              8'hA1, 8'h29, 18, 21};
    tv[2] = '{72'hFF00FF00FF00FF0080, 32'hFFFF_FFF8,
              8'hFF, 8'h80, 13, 14};
    tv[3] = '{72'h123456789ABCDEF011, 32'h5555_5555,
              8'h12, 8'h11, 18, 20};

    rst       = 1'b1;
    out_ready = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(rec_count), 64'd0);
    chk("rst_data", 64'({out_data, out_sop, out_eop}), 64'd0);
    chk("rst_pop", 64'(fifo_pop), 64'd0);

    // Empty FIFO with ready high: nothing may move.
    out_ready = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      bad |= fifo_pop | out_valid | busy;
    end
    chk("idle_quiet", 64'(bad), 64'd0);
    out_ready = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(tv[i]);

    // Three queued records stream back to back.
    obq.delete();
    pops = 0;
    vcyc = 0;
    fq.push_back(72'h111111111111111111);
    fq.push_back(72'h222222222222222222);
    fq.push_back(72'h333333333333333333);
    drive_fifo();
    out_ready = 1'b1;
    tick();
    t = 1;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    chk("b2b_ticks", 64'(t), 64'(1 + 3 * FL));
    chk("b2b_valid", 64'(vcyc), 64'(3 * FL));
    chk("b2b_pops", 64'(pops), 64'd3);
    chk("b2b_count", 64'(rec_count), 64'd7);
    chk("b2b_bytes", 64'(obq.size()), 64'(3 * FL));

`ifdef EVT_SER_CRC_EN
    // Record 0x00..01 gives CRC 0x07 over ten handshakes.
    obq.delete();
    fq.push_back(72'h000000000000000001);
    drive_fifo();
    out_ready = 1'b1;
    t = 0;
    last_eop = 0;
    while (!last_eop && t < 40) begin
      tick();
      t++;
    end
    chk("crc_hs", 64'(obq.size()), 64'd10);
    if (obq.size() == 10) begin
      chk("crc_val", 64'(obq[9].d), 64'h07);
      chk("crc_eop", 64'(obq[9].e), 64'd1);
      chk("crc_d8eop", 64'(obq[8].e), 64'd0);
    end
`endif

    // Reset after four bytes discards the record.
    obq.delete();
    fq.push_back(72'hAABBCCDDEEFF112233);
    fq.push_back(72'h5566778899AABBCCDD);
    drive_fifo();
    out_ready = 1'b1;
    repeat (5) tick();
    chk("mid_bytes", 64'(obq.size()), 64'd4);
    rst       = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_count", 64'(rec_count), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    #1;
    chk("mr_pop", 64'(fifo_pop), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("mr_nvalid", 64'(out_valid), 64'd1);
    chk("mr_nsop", 64'(out_sop), 64'd1);
    chk("mr_ndata", 64'(out_data), 64'h55);
    obq.delete();
    t = 0;
    last_eop = 0;
    while (!last_eop && t < 40) begin
      tick();
      t++;
    end
    check_frame(72'h5566778899AABBCCDD);
    chk("mr_count2", 64'(rec_count), 64'd1);
    chk("mr_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
